fifo_flex: RTL and testbench

Parametrised single-clock synchronous FIFO for the hamming_ecc datapath, the successor to the fixed two-entry buffer. It adds:
- arbitrary (non-power-of-two) depth;
- selectable registered-read or first-word-fall-through (FWFT) output;
- programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a peak-occupancy watermark for buffer sizing.

It sits between the ECC encoder/decoder stages and downstream consumers.

---
 rtl/fifo_flex.sv | 133 +++++++++++++
 tb/tb_fifo_flex.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// Parametrised single-clock synchronous FIFO with arbitrary depth, registered or
// first-word-fall-through read, programmable thresholds, sticky error flags and peak watermark.
module fifo_flex #(
  parameter int FW   = 512,
  parameter int FD   = 4,
  parameter int CW   = $clog2(FD + 1),
  parameter int FWFT = 0,
  parameter int AFT  = FD - 1,
  parameter int AET  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ffbwreq,
  input  logic          ffbrreq,
  input  logic [FW-1:0] ffbdi,
  input  logic          errclr,
  output logic [FW-1:0] ffbdo,
  output logic          ffbvalid,
  output logic          ffbempty,
  output logic          ffbfull,
  output logic          ffbafull,
  output logic          ffbaempty,
  output logic [CW-1:0] ffbvcnt,
  output logic          ffbovf,
  output logic          ffbudf,
  output logic [CW-1:0] ffbpeak
);

  localparam int AW = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [CW-1:0] PTR_LAST = CW'(FD - 1);

  logic [FW-1:0] mem [0:FD-1];
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] vcnt_nxt;
  logic [CW-1:0] peak;
  logic [CW-1:0] peak_nxt;
  logic          ovf;
  logic          udf;
  logic          wacc;
  logic          racc;

  assign ffbempty  = (vcnt == '0);
  assign ffbfull   = (vcnt == CW'(FD));
  assign ffbafull  = (vcnt >= CW'(AFT));
  assign ffbaempty = (vcnt <= CW'(AET));
  assign ffbvcnt   = vcnt;
  assign ffbovf    = ovf;
  assign ffbudf    = udf;
  assign ffbpeak   = peak;

  // A write while full is dropped even when a read frees a slot in the same cycle.
  assign wacc = ffbwreq & ~ffbfull;
  assign racc = ffbrreq & ~ffbempty;

  always_comb begin
    vcnt_nxt = vcnt;
    case ({wacc, racc})
      2'b10:   vcnt_nxt = vcnt + 1'b1;
      2'b01:   vcnt_nxt = vcnt - 1'b1;
      default: vcnt_nxt = vcnt;
    endcase
    peak_nxt = (vcnt_nxt > peak) ? vcnt_nxt : peak;
  end

  always_ff @(posedge clk) begin
    if (!reset && wacc) begin
      mem[wptr[AW-1:0]] <= ffbdi;
    end
  end

  // Pointers wrap explicitly at FD-1 so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      vcnt <= '0;
    end else begin
      if (wacc) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (racc) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      vcnt <= vcnt_nxt;
    end
  end

  // A set event coinciding with errclr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf  <= 1'b0;
      udf  <= 1'b0;
      peak <= '0;
    end else if (errclr) begin
      ovf  <= ffbwreq & ffbfull;
      udf  <= ffbrreq & ffbempty;
      peak <= vcnt_nxt;
    end else begin
      ovf  <= ovf | (ffbwreq & ffbfull);
      udf  <= udf | (ffbrreq & ffbempty);
      peak <= peak_nxt;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign ffbdo    = mem[rptr[AW-1:0]];
      assign ffbvalid = ~ffbempty;
    end else begin : g_regrd
      logic [FW-1:0] dout_q;
      logic          valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= racc;
          if (racc) dout_q <= mem[rptr[AW-1:0]];
        end
      end

      assign ffbdo    = dout_q;
      assign ffbvalid = valid_q;
    end
  endgenerate

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && ffbwreq && ffbfull) $warning("fifo_flex: write request while full, data dropped");
    if (!reset && ffbrreq && ffbempty) $warning("fifo_flex: read request while empty, ignored");
  end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a depth-5 registered-read instance and a depth-4 FWFT instance.
module tb_fifo_flex;

  logic clk;
  logic reset;

  logic       wreq0, rreq0, errclr0;
  logic [7:0] di0, do0;
  logic       valid0, empty0, full0, afull0, aempty0, ovf0, udf0;
  logic [2:0] vcnt0, peak0;

  logic       wreq1, rreq1, errclr1;
  logic [7:0] di1, do1;
  logic       valid1, empty1, full1, afull1, aempty1, ovf1, udf1;
  logic [2:0] vcnt1, peak1;

  int evaluated = 0;
  int failures  = 0;

  fifo_flex #(.FW(8), .FD(5), .FWFT(0), .AFT(4), .AET(1)) u_reg (
    .clk(clk), .reset(reset), .ffbwreq(wreq0), .ffbrreq(rreq0), .ffbdi(di0),
    .errclr(errclr0), .ffbdo(do0), .ffbvalid(valid0), .ffbempty(empty0),
    .ffbfull(full0), .ffbafull(afull0), .ffbaempty(aempty0), .ffbvcnt(vcnt0),
    .ffbovf(ovf0), .ffbudf(udf0), .ffbpeak(peak0)
  );

  fifo_flex #(.FW(8), .FD(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .ffbwreq(wreq1), .ffbrreq(rreq1), .ffbdi(di1),
    .errclr(errclr1), .ffbdo(do1), .ffbvalid(valid1), .ffbempty(empty1),
    .ffbfull(full1), .ffbafull(afull1), .ffbaempty(aempty1), .ffbvcnt(vcnt1),
    .ffbovf(ovf1), .ffbudf(udf1), .ffbpeak(peak1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wreq0 = 1'b1; rreq0 = 1'b0; errclr0 = 1'b0; di0 = 8'h55;
    wreq1 = 1'b1; rreq1 = 1'b0; errclr1 = 1'b0; di1 = 8'h55;

    // Reset held 3 cycles with write requests asserted
    repeat (3) tick();
    check("rst_vcnt0",   32'(vcnt0),   0);
    check("rst_empty0",  32'(empty0),  1);
    check("rst_aempty0", 32'(aempty0), 1);
    check("rst_full0",   32'(full0),   0);
    check("rst_afull0",  32'(afull0),  0);
    check("rst_ovf0",    32'(ovf0),    0);
    check("rst_udf0",    32'(udf0),    0);
    check("rst_peak0",   32'(peak0),   0);
    check("rst_valid0",  32'(valid0),  0);
    check("rst_do0",     32'(do0),     0);
    check("rst_vcnt1",   32'(vcnt1),   0);
    check("rst_valid1",  32'(valid1),  0);
    reset = 1'b0; wreq0 = 1'b0; wreq1 = 1'b0;

    // Depth 5: fill with 0x01..0x05
    for (int i = 1; i <= 5; i++) begin
      wreq0 = 1'b1; di0 = 8'(i);
      tick();
      check("fill_vcnt", 32'(vcnt0), 32'(i));
    end
    wreq0 = 1'b0;
    check("fill_full",   32'(full0),   1);
    check("fill_afull",  32'(afull0),  1);
    check("fill_aempty", 32'(aempty0), 0);
    check("fill_valid",  32'(valid0),  0);

    rreq0 = 1'b1;
    tick();
    check("rd1_do",    32'(do0),    8'h01);
    check("rd1_valid", 32'(valid0), 1);
    check("rd1_afull", 32'(afull0), 1);
    tick();
    check("rd2_do",    32'(do0),    8'h02);
    check("rd2_afull", 32'(afull0), 0);
    rreq0 = 1'b0;
    tick();
    check("idle_valid", 32'(valid0), 0);
    check("idle_hold",  32'(do0),    8'h02);
    check("idle_vcnt",  32'(vcnt0),  3);

    // Writes wrap past entry 4 back to entry 0
    wreq0 = 1'b1; di0 = 8'h06;
    tick();
    di0 = 8'h07;
    tick();
    wreq0 = 1'b0;
    check("wrap_vcnt", 32'(vcnt0), 5);
    check("wrap_full", 32'(full0), 1);

    rreq0 = 1'b1;
    for (int i = 3; i <= 7; i++) begin
      tick();
      check("drain_do",    32'(do0),    32'(i));
      check("drain_valid", 32'(valid0), 1);
    end
    rreq0 = 1'b0;
    check("drain_empty", 32'(empty0), 1);
    check("drain_vcnt",  32'(vcnt0),  0);
    check("drain_ovf",   32'(ovf0),   0);
    check("drain_peak",  32'(peak0),  5);

    // FWFT: one-cycle write-to-read latency, pop empties it
    wreq1 = 1'b1; di1 = 8'hAA;
    tick();
    wreq1 = 1'b0;
    check("fwft_valid", 32'(valid1), 1);
    check("fwft_do",    32'(do1),    8'hAA);
    check("fwft_vcnt",  32'(vcnt1),  1);
    rreq1 = 1'b1;
    tick();
    rreq1 = 1'b0;
    check("pop_valid", 32'(valid1), 0);
    check("pop_vcnt",  32'(vcnt1),  0);
    check("pop_empty", 32'(empty1), 1);

    // Full boundary: simultaneous write and read while full
    for (int i = 0; i < 4; i++) begin
      wreq1 = 1'b1; di1 = 8'(8'h10 + i);
      tick();
    end
    wreq1 = 1'b0;
    check("full_full",  32'(full1),  1);
    check("full_afull", 32'(afull1), 1);
    check("full_do",    32'(do1),    8'h10);
    wreq1 = 1'b1; rreq1 = 1'b1; di1 = 8'h99;
    tick();
    wreq1 = 1'b0; rreq1 = 1'b0;
    check("fb_vcnt", 32'(vcnt1), 3);
    check("fb_ovf",  32'(ovf1),  1);
    check("fb_full", 32'(full1), 0);
    check("fb_do",   32'(do1),   8'h11);
    rreq1 = 1'b1;
    tick();
    check("fb_pop1", 32'(do1), 8'h12);
    tick();
    check("fb_pop2", 32'(do1), 8'h13);
    tick();
    rreq1 = 1'b0;
    check("fb_empty",  32'(empty1), 1);
    check("fb_ovf_st", 32'(ovf1),   1);
    check("fb_udf",    32'(udf1),   0);
    check("fb_peak",   32'(peak1),  4);

    // Empty boundary: simultaneous write and read while empty
    wreq1 = 1'b1; rreq1 = 1'b1; di1 = 8'h5A;
    tick();
    wreq1 = 1'b0; rreq1 = 1'b0;
    check("eb_vcnt",  32'(vcnt1),  1);
    check("eb_udf",   32'(udf1),   1);
    check("eb_do",    32'(do1),    8'h5A);
    check("eb_valid", 32'(valid1), 1);
    rreq1 = 1'b1;
    tick();
    rreq1 = 1'b0;
    check("eb_pop_vcnt", 32'(vcnt1), 0);
    check("eb_udf_st",   32'(udf1),  1);

    errclr1 = 1'b1; rreq1 = 1'b1;
    tick();
    rreq1 = 1'b0;
    check("clr_set_udf",  32'(udf1),  1);
    check("clr_set_ovf",  32'(ovf1),  0);
    check("clr_set_peak", 32'(peak1), 0);
    tick();
    errclr1 = 1'b0;
    check("clr_udf", 32'(udf1), 0);

    // Watermark: fill 3, drain, clear, fill 1
    for (int i = 0; i < 3; i++) begin
      wreq1 = 1'b1; di1 = 8'(8'h21 + i);
      tick();
    end
    wreq1 = 1'b0;
    check("wm_fill_peak",  32'(peak1),  3);
    check("wm_fill_afull", 32'(afull1), 1);
    rreq1 = 1'b1;
    repeat (3) tick();
    rreq1 = 1'b0;
    check("wm_drain_vcnt", 32'(vcnt1), 0);
    check("wm_drain_peak", 32'(peak1), 3);
    errclr1 = 1'b1;
    tick();
    errclr1 = 1'b0;
    check("wm_clr_peak", 32'(peak1), 0);
    wreq1 = 1'b1; di1 = 8'h77;
    tick();
    wreq1 = 1'b0;
    check("wm_one_peak", 32'(peak1), 1);
    check("wm_one_do",   32'(do1),   8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
